// File: rtl/rv32_state_dumper.sv
// rv32_state_dumper: freezes the core and streams a byte frame of
// {header, pc, x0..x(NUM_REGS-1), checksum} over a valid/ready byte link.
// Every multi-byte word is sent little-endian. The checksum is the mod-256
// sum of all preceding frame bytes, including the header.
module rv32_state_dumper #(
    parameter logic [7:0] HEADER_BYTE = 8'hA5,
    parameter int         NUM_REGS    = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        dump_start,
    input  logic [31:0] pc,
    output logic [4:0]  reg_read_addr,
    input  logic [31:0] reg_read_data,
    output logic        freeze,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        done
);

    localparam logic [4:0] LAST_REG = 5'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        PC_BYTES,
        REG_LOAD,
        REG_BYTES,
        CHECKSUM
    } state_t;

    state_t      state, state_n;
    logic [31:0] word_buf, word_buf_n;
    logic [1:0]  byte_cnt, byte_cnt_n;
    logic [7:0]  checksum, checksum_n;
    logic [4:0]  reg_read_addr_n;
    logic        done_n;
    logic        xfer;

    // The handshake completes when a valid byte meets a ready sink.
    assign xfer = tx_valid && tx_ready;

    // State and datapath registers; reset returns everything to its idle values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            word_buf      <= '0;
            byte_cnt      <= '0;
            checksum      <= '0;
            reg_read_addr <= '0;
            done          <= 1'b0;
        end else begin
            state         <= state_n;
            word_buf      <= word_buf_n;
            byte_cnt      <= byte_cnt_n;
            checksum      <= checksum_n;
            reg_read_addr <= reg_read_addr_n;
            done          <= done_n;
        end
    end

    // Next-state and output logic. tx_valid and tx_data depend only on the
    // registered state, never on tx_ready.
    always_comb begin
        state_n         = state;
        word_buf_n      = word_buf;
        byte_cnt_n      = byte_cnt;
        checksum_n      = checksum;
        reg_read_addr_n = reg_read_addr;
        done_n          = 1'b0;
        tx_valid        = 1'b0;
        tx_data         = '0;
        freeze          = (state != IDLE);

        case (state)
            IDLE: begin
                if (dump_start) begin
                    word_buf_n      = pc;
                    checksum_n      = '0;
                    reg_read_addr_n = '0;
                    byte_cnt_n      = '0;
                    state_n         = HEADER;
                end
            end

            HEADER: begin
                tx_valid = 1'b1;
                tx_data  = HEADER_BYTE;
                if (xfer) begin
                    checksum_n = checksum + HEADER_BYTE;
                    byte_cnt_n = '0;
                    state_n    = PC_BYTES;
                end
            end

            PC_BYTES: begin
                tx_valid = 1'b1;
                tx_data  = word_buf[7:0];
                if (xfer) begin
                    checksum_n = checksum + word_buf[7:0];
                    word_buf_n = {8'h00, word_buf[31:8]};
                    byte_cnt_n = byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) begin
                        state_n = REG_LOAD;
                    end
                end
            end

            // Single bubble cycle: the register file read of reg_read_addr
            // is captured here, independent of the sink.
            REG_LOAD: begin
                word_buf_n = reg_read_data;
                byte_cnt_n = '0;
                state_n    = REG_BYTES;
            end

            REG_BYTES: begin
                tx_valid = 1'b1;
                tx_data  = word_buf[7:0];
                if (xfer) begin
                    checksum_n = checksum + word_buf[7:0];
                    word_buf_n = {8'h00, word_buf[31:8]};
                    byte_cnt_n = byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) begin
                        if (reg_read_addr == LAST_REG) begin
                            state_n = CHECKSUM;
                        end else begin
                            reg_read_addr_n = reg_read_addr + 5'd1;
                            state_n         = REG_LOAD;
                        end
                    end
                end
            end

            CHECKSUM: begin
                tx_valid = 1'b1;
                tx_data  = checksum;
                if (xfer) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: doc/rv32_state_dumper.md
# rv32_state_dumper

Synthesizable read-out engine for the rv32i core's architectural state. On a start pulse it freezes the core, reads `pc` and registers x0..x31 through a register-file read port, and streams them as a fixed byte frame over a valid/ready byte interface to a host link such as a UART TX or debug FIFO. It is the read direction of the simulation-only memory and register preload path. It sits beside `register_file_0` in `test_bench_rv32` and in the FPGA top level.

## Interface
Parameters:
- `HEADER_BYTE`, default 8'hA5: first byte of every frame.
- `NUM_REGS`, default 32: registers dumped, x0 upward. Legal range 1..32.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `dump_start`  in  1  single-cycle request; honoured only in IDLE.
- `pc`  in  32  core program counter; sampled on the accepted `dump_start` cycle.
- `reg_read_addr`  out  5  register index presented to the register file (registered).
- `reg_read_data`  in  32  combinational register-file read of `reg_read_addr`.
- `freeze`  out  1  high while a frame is in progress; the core ANDs it into `enable`.
- `tx_data`  out  8  frame byte.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_ready`  in  1  sink accepts the byte; a transfer occurs when `tx_valid && tx_ready` at a rising edge.
- `done`  out  1  one-cycle pulse after the checksum byte transfers.

## Operation
Frame is 1 + 4 + 4·NUM_REGS + 1 bytes; 134 bytes at the default:
- `HEADER_BYTE`.
- `pc`, little-endian.
- Each of x0..x(NUM_REGS-1), little-endian.
- Checksum: 8-bit sum, mod 256, of all preceding frame bytes including the header.

State machine:
- **IDLE**: `tx_valid`=0, `freeze`=0. `dump_start`=1 → latch `pc` into `word_buf`, clear `checksum`, set `reg_read_addr`=0, go to HEADER.
- **HEADER**: `tx_data`=`HEADER_BYTE`. On transfer → PC_BYTES with `byte_cnt`=0.
- **PC_BYTES**: `tx_data`=`word_buf[7:0]`. Each transfer shifts `word_buf` right 8 and increments `byte_cnt`. Transfer at `byte_cnt`=3 → REG_LOAD.
- **REG_LOAD**: `tx_valid`=0 for exactly one cycle. Captures `reg_read_data` into `word_buf`, then → REG_BYTES with `byte_cnt`=0.
- **REG_BYTES**: same as PC_BYTES. Transfer at `byte_cnt`=3:
  - if `reg_read_addr`==NUM_REGS-1 → CHECKSUM;
  - else increment `reg_read_addr` and → REG_LOAD.
- **CHECKSUM**: `tx_data`=`checksum`. On transfer → IDLE and pulse `done`.

Rules:
- `checksum` accumulates `tx_data` on every transfer from HEADER, PC_BYTES and REG_BYTES. It is 8 bits wide and wraps.
- `dump_start` outside IDLE is ignored; it is neither queued nor allowed to restart the frame.
- x0 is dumped as whatever the register file returns. The block does not force it to zero.
- `pc` changes after the sample cycle do not affect the frame.

## Timing
- Reset values: `tx_valid`=0, `tx_data`=0, `freeze`=0, `done`=0, `reg_read_addr`=0, state IDLE, `checksum`=0, `byte_cnt`=0.
- `dump_start` accepted at edge 0:
  - `freeze` and `tx_valid` go high after edge 0;
  - the header is on `tx_data` in cycle 1.
- Valid/ready rules:
  - Once `tx_valid` is high, `tx_valid` and `tx_data` stay stable until the transfer.
  - `tx_valid` never depends combinationally on `tx_ready`.
- Latency with `tx_ready` held at 1 and NUM_REGS=32:
  - header in cycle 1; pc in cycles 2–5;
  - register k loads in cycle 6+5k and sends in cycles 7+5k..10+5k;
  - checksum in cycle 166;
  - `done`=1 and `freeze`=0 in cycle 167.
- Stalls from `tx_ready`=0 add cycles one-for-one. REG_LOAD never waits on `tx_ready`.
- `freeze` stays high from cycle 1 through the checksum transfer cycle, inclusive.
- `reset` mid-frame forces all reset values at the next edge. The partial frame is abandoned, with no checksum and no `done`.
- `reset` and `dump_start` in the same cycle: reset wins.
- `done` and a new `dump_start` in the same cycle: the start is accepted, because the state is already IDLE.

## Test plan
- **Zero state**: `pc`=0, all registers 0, `tx_ready`=1, pulse start → bytes A5, then 132×00, then checksum A5; `done` in cycle 167; `freeze` high cycles 1–166.
- **Pattern**: `pc`=0x00000004, xi=0x11111111·(i mod 16), `tx_ready`=1 → pc bytes 04 00 00 00; x1 bytes 11 11 11 11; x15 bytes FF FF FF FF; checksum equals the bench-computed mod-256 sum.
- **Backpressure**: `tx_ready` random with 50% duty → byte sequence identical to the `tx_ready`=1 run; `tx_data` never changes while `tx_valid && !tx_ready`; total cycles = 167 + stall cycles.
- **Ignored start**: `dump_start` pulsed in cycles 3, 50 and 166 of a frame → exactly one frame and one `done`; `pc` changes mid-frame absent from the output.
- **Reset mid-frame**: `reset` in cycle 40 → `tx_valid`=`freeze`=0 next cycle and no `done`; a new start then gives a complete, correct frame beginning with A5.
- **Back-to-back**: `dump_start` asserted in the `done` cycle → second frame header in the following cycle; frames identical for unchanged state.
